// File: rtl/pool_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pool_ctrl_pkg
// Description : Shared data width, sequencer state encoding and counter sizing
//               helper for the pooling sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package pool_ctrl_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        POOL_IDLE = 3'd0,
        POOL_RD   = 3'd1,
        POOL_LAST = 3'd2,
        POOL_WR   = 3'd3,
        POOL_DONE = 3'd4
    } pool_state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pool_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : pool_addr_gen
// Description : Window/sample counters and SRAM address generation for the
//               2x2 stride-2 pooling walk.
// Revision    : 1.0 - initial release
// ============================================================================
module pool_addr_gen
    import pool_ctrl_pkg::*;
#(
    parameter int IMG_W     = 8,
    parameter int IMG_H     = 8,
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 k_step,
    input  logic                 win_step,
    input  logic [ADDR_BITS-1:0] in_base,
    input  logic [ADDR_BITS-1:0] out_base,
    output logic                 last_k,
    output logic                 last_win,
    output logic [ADDR_BITS-1:0] rd_addr,
    output logic [ADDR_BITS-1:0] wr_addr
);

    localparam int c_COLS = IMG_W / 2;
    localparam int c_ROWS = IMG_H / 2;
    localparam int c_CW   = cnt_width(c_COLS);
    localparam int c_RW   = cnt_width(c_ROWS);
    localparam logic [c_CW-1:0] c_C_LAST = c_CW'(c_COLS - 1);
    localparam logic [c_RW-1:0] c_R_LAST = c_RW'(c_ROWS - 1);

    logic [1:0]           r_k;
    logic [c_CW-1:0]      r_c;
    logic [c_RW-1:0]      r_r;
    logic [ADDR_BITS-1:0] r_in_base;
    logic [ADDR_BITS-1:0] r_out_base;

    logic [ADDR_BITS-1:0] w_rd_row;
    logic [ADDR_BITS-1:0] w_rd_col;
    logic [ADDR_BITS-1:0] w_wr_row;
    logic [ADDR_BITS-1:0] w_wr_col;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k        <= '0;
            r_c        <= '0;
            r_r        <= '0;
            r_in_base  <= '0;
            r_out_base <= '0;
        end else if (load) begin
            r_k        <= '0;
            r_c        <= '0;
            r_r        <= '0;
            r_in_base  <= in_base;
            r_out_base <= out_base;
        end else begin
            if (k_step) begin
                r_k <= r_k + 2'd1;
            end
            if (win_step) begin
                if (r_c == c_C_LAST) begin
                    r_c <= '0;
                    r_r <= (r_r == c_R_LAST) ? '0 : r_r + c_RW'(1);
                end else begin
                    r_c <= r_c + c_CW'(1);
                end
            end
        end
    end

    // {r,k[1]} is the pixel row 2r+k[1]; {c,k[0]} is the pixel column 2c+k[0].
    always_comb begin
        w_rd_row = ADDR_BITS'({r_r, r_k[1]});
        w_rd_col = ADDR_BITS'({r_c, r_k[0]});
        w_wr_row = ADDR_BITS'(r_r);
        w_wr_col = ADDR_BITS'(r_c);
    end

    assign rd_addr  = r_in_base + w_rd_row * ADDR_BITS'(IMG_W) + w_rd_col;
    assign wr_addr  = r_out_base + w_wr_row * ADDR_BITS'(c_COLS) + w_wr_col;
    assign last_k   = (r_k == 2'd3);
    assign last_win = (r_c == c_C_LAST) && (r_r == c_R_LAST);

endmodule
`default_nettype wire

// File: rtl/pool_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pool_ctrl
// Description : Sequencer driving input SRAM reads, the Pooling max unit and
//               output SRAM writes over 2x2 stride-2 windows.
// Revision    : 1.0 - initial release
// ============================================================================
module pool_ctrl
    import pool_ctrl_pkg::*;
#(
    parameter int IMG_W     = 8,
    parameter int IMG_H     = 8,
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] in_base,
    input  logic [ADDR_BITS-1:0] out_base,
    output logic                 busy,
    output logic                 done,
    output logic                 rd_en,
    output logic [ADDR_BITS-1:0] rd_addr,
    output logic                 pool_en,
    input  logic [DATA_BITS-1:0] pool_data,
    output logic                 wr_en,
    output logic [ADDR_BITS-1:0] wr_addr,
    output logic [DATA_BITS-1:0] wr_data
);

    pool_state_t r_state;
    pool_state_t w_state_nxt;
    logic        r_pool_en;
    logic        w_load;
    logic        w_k_step;
    logic        w_win_step;
    logic        w_last_k;
    logic        w_last_win;

    pool_addr_gen #(
        .IMG_W     (IMG_W),
        .IMG_H     (IMG_H),
        .ADDR_BITS (ADDR_BITS)
    ) u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load),
        .k_step   (w_k_step),
        .win_step (w_win_step),
        .in_base  (in_base),
        .out_base (out_base),
        .last_k   (w_last_k),
        .last_win (w_last_win),
        .rd_addr  (rd_addr),
        .wr_addr  (wr_addr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= POOL_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // SRAM read latency is one cycle, so Pooling sees data one cycle after rd_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pool_en <= 1'b0;
        end else begin
            r_pool_en <= (r_state == POOL_RD);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_k_step    = 1'b0;
        w_win_step  = 1'b0;
        rd_en       = 1'b0;
        wr_en       = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            POOL_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = POOL_RD;
                end
            end
            POOL_RD: begin
                busy     = 1'b1;
                rd_en    = 1'b1;
                w_k_step = 1'b1;
                if (w_last_k) begin
                    w_state_nxt = POOL_LAST;
                end
            end
            POOL_LAST: begin
                busy        = 1'b1;
                w_state_nxt = POOL_WR;
            end
            POOL_WR: begin
                busy        = 1'b1;
                wr_en       = 1'b1;
                w_win_step  = 1'b1;
                w_state_nxt = w_last_win ? POOL_DONE : POOL_RD;
            end
            POOL_DONE: begin
                done        = 1'b1;
                w_state_nxt = POOL_IDLE;
            end
            default: begin
                w_state_nxt = POOL_IDLE;
            end
        endcase
    end

    assign pool_en = r_pool_en;
    assign wr_data = pool_data;

endmodule
`default_nettype wire

// File: tb/tb_pool_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pool_ctrl
// Description : Self-checking bench: 8x8 instance for full passes, 2x2 instance
//               with 4-bit addresses for single-window and wrap cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pool_ctrl;
    import pool_ctrl_pkg::*;

    localparam int AW = 10;
    localparam int BW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- instance A: 8x8, 10-bit addresses ----------------
    logic                 a_start, a_busy, a_done, a_rd_en, a_pool_en, a_wr_en;
    logic [AW-1:0]        a_in_base, a_out_base, a_rd_addr, a_wr_addr;
    logic [DATA_BITS-1:0] a_pool_data, a_wr_data;

    pool_ctrl #(.IMG_W(8), .IMG_H(8), .ADDR_BITS(AW)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .in_base(a_in_base), .out_base(a_out_base),
        .busy(a_busy), .done(a_done), .rd_en(a_rd_en), .rd_addr(a_rd_addr), .pool_en(a_pool_en),
        .pool_data(a_pool_data), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data)
    );

    // ---------------- instance B: 2x2, 4-bit addresses ----------------
    logic                 b_start, b_busy, b_done, b_rd_en, b_pool_en, b_wr_en;
    logic [BW-1:0]        b_in_base, b_out_base, b_rd_addr, b_wr_addr;
    logic [DATA_BITS-1:0] b_pool_data, b_wr_data;

    pool_ctrl #(.IMG_W(2), .IMG_H(2), .ADDR_BITS(BW)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .in_base(b_in_base), .out_base(b_out_base),
        .busy(b_busy), .done(b_done), .rd_en(b_rd_en), .rd_addr(b_rd_addr), .pool_en(b_pool_en),
        .pool_data(b_pool_data), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data)
    );

    // Environment: synchronous-read SRAM plus a Pooling max register that clears when en is low.
    logic [DATA_BITS-1:0] a_mem [1024];
    logic [DATA_BITS-1:0] b_mem [16];
    logic [DATA_BITS-1:0] a_q, a_max, b_q, b_max;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0; a_max <= '0; b_q <= '0; b_max <= '0;
        end else begin
            if (a_rd_en) a_q <= a_mem[a_rd_addr];
            if (b_rd_en) b_q <= b_mem[b_rd_addr];
            a_max <= a_pool_en ? ((a_q > a_max) ? a_q : a_max) : '0;
            b_max <= b_pool_en ? ((b_q > b_max) ? b_q : b_max) : '0;
        end
    end
    assign a_pool_data = a_max;
    assign b_pool_data = b_max;

    // Write log and cycle counters for instance A.
    int a_wa[$];
    int a_wd[$];
    int a_busy_cnt = 0, a_done_cnt = 0, a_last_wr_cyc = 0, a_done_cyc = 0;
    always @(negedge clk) begin
        if (a_wr_en) begin
            a_wa.push_back(int'(a_wr_addr));
            a_wd.push_back(int'(a_wr_data));
            a_last_wr_cyc <= cyc;
        end
        if (a_busy) a_busy_cnt <= a_busy_cnt + 1;
        if (a_done) begin
            a_done_cnt <= a_done_cnt + 1;
            a_done_cyc <= cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: maximum of the 2x2 window (r,c) of the 8x8 map at ib.
    function automatic int ref_max_a(input int ib, input int r, input int c);
        int m, v;
        m = 0;
        for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++) begin
                v = int'(a_mem[(ib + (2 * r + dy) * 8 + 2 * c + dx) % 1024]);
                if (v > m) m = v;
            end
        return m;
    endfunction

    int a_wq_base, a_busy_base, a_done_base;

    // Called at a negedge while A is idle; returns at the negedge of the first RD cycle.
    task automatic start_a(input int ib, input int ob);
        a_wq_base   = a_wa.size();
        a_busy_base = a_busy_cnt;
        a_done_base = a_done_cnt;
        a_in_base   = AW'(ib);
        a_out_base  = AW'(ob);
        a_start     = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        chk("a_busy_rise", int'(a_busy), 1);
        chk("a_first_rd_addr", int'(a_rd_addr), ib % 1024);
        chk("a_first_pool_en", int'(a_pool_en), 0);
    endtask

    // Waits for done, then checks the whole pass; returns at the IDLE negedge after done.
    task automatic check_pass_a(input int ib, input int ob, input string tag);
        int n, idx, oa, od;
        n = 0;
        while (a_done !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, int'(a_done), 1);
        @(negedge clk);
        chk({tag, "_done_pulse"}, int'(a_done), 0);
        chk({tag, "_done_count"}, a_done_cnt - a_done_base, 1);
        chk({tag, "_busy_cycles"}, a_busy_cnt - a_busy_base, 96);
        chk({tag, "_done_after_wr"}, a_done_cyc - a_last_wr_cyc, 1);
        chk({tag, "_write_count"}, a_wa.size() - a_wq_base, 16);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                idx = a_wq_base + r * 4 + c;
                oa  = (idx < a_wa.size()) ? a_wa[idx] : -1;
                od  = (idx < a_wd.size()) ? a_wd[idx] : -1;
                chk($sformatf("%s_wr_addr_%0d_%0d", tag, r, c), oa, (ob + r * 4 + c) % 1024);
                chk($sformatf("%s_wr_data_%0d_%0d", tag, r, c), od, ref_max_a(ib, r, c));
            end
    endtask

    // Single-window run on instance B, cycle by cycle; also pulses start during DONE.
    task automatic run_b(input int ib, input int ob, input string tag);
        int exp_max, v;
        exp_max = 0;
        for (int j = 0; j < 4; j++) begin
            v = int'(b_mem[(ib + (j / 2) * 2 + (j % 2)) % 16]);
            if (v > exp_max) exp_max = v;
        end
        b_in_base  = BW'(ib);
        b_out_base = BW'(ob);
        b_start    = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int t = 0; t < 6; t++) begin
            chk($sformatf("%s_pool_en_t%0d", tag, t), int'(b_pool_en), (t >= 1 && t <= 4) ? 1 : 0);
            chk($sformatf("%s_rd_en_t%0d", tag, t), int'(b_rd_en), (t < 4) ? 1 : 0);
            chk($sformatf("%s_wr_en_t%0d", tag, t), int'(b_wr_en), (t == 5) ? 1 : 0);
            if (t < 4)
                chk($sformatf("%s_rd_addr_k%0d", tag, t), int'(b_rd_addr), (ib + (t / 2) * 2 + (t % 2)) % 16);
            if (t == 5) begin
                chk({tag, "_wr_data"}, int'(b_wr_data), exp_max);
                chk({tag, "_wr_addr"}, int'(b_wr_addr), ob % 16);
            end
            @(negedge clk);
        end
        chk({tag, "_done"}, int'(b_done), 1);
        chk({tag, "_busy_in_done"}, int'(b_busy), 0);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        chk({tag, "_start_in_done_ignored"}, int'(b_busy), 0);
        chk({tag, "_no_rd_after_done"}, int'(b_rd_en), 0);
    endtask

    int wbase;

    initial begin
        a_start = 1'b0; a_in_base = '0; a_out_base = '0;
        b_start = 1'b0; b_in_base = '0; b_out_base = '0;
        for (int i = 0; i < 1024; i++) a_mem[i] = DATA_BITS'($urandom);
        for (int i = 0; i < 16; i++) b_mem[i] = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(a_busy), 0);
        chk("rst_done", int'(a_done), 0);
        chk("rst_rd_en", int'(a_rd_en), 0);
        chk("rst_pool_en", int'(a_pool_en), 0);
        chk("rst_wr_en", int'(a_wr_en), 0);
        chk("rst_rd_addr", int'(a_rd_addr), 0);
        chk("rst_wr_addr", int'(a_wr_addr), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic random pass
        start_a(0, 512);
        check_pass_a(0, 512, "basic");

        // Start while busy: new bases presented but must not be latched
        start_a(64, 300);
        repeat (3) @(negedge clk);
        a_in_base  = AW'(500);
        a_out_base = AW'(900);
        a_start    = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        check_pass_a(64, 300, "busy_start");

        // Reset during the third window's RD phase
        start_a(128, 700);
        repeat (13) @(negedge clk);
        chk("rst_mid_pre_rd_en", int'(a_rd_en), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", int'(a_busy), 0);
        chk("rst_mid_rd_en", int'(a_rd_en), 0);
        chk("rst_mid_pool_en", int'(a_pool_en), 0);
        chk("rst_mid_wr_en", int'(a_wr_en), 0);
        chk("rst_mid_done", int'(a_done), 0);
        chk("rst_mid_rd_addr", int'(a_rd_addr), 0);
        chk("rst_mid_wr_addr", int'(a_wr_addr), 0);
        wbase = a_wa.size();
        repeat (3) @(negedge clk);
        chk("rst_mid_no_writes", a_wa.size() - wbase, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_waits_start", int'(a_busy), 0);
        start_a(128, 700);
        check_pass_a(128, 700, "post_rst");

        // Back-to-back: high-valued pass, then low-valued pass started in the IDLE cycle after done
        for (int i = 0; i < 64; i++) a_mem[i] = DATA_BITS'($urandom_range(240, 255));
        for (int i = 100; i < 164; i++) a_mem[i] = DATA_BITS'($urandom_range(0, 15));
        start_a(0, 400);
        check_pass_a(0, 400, "b2b_first");
        start_a(100, 200);
        check_pass_a(100, 200, "b2b_second");

        // Max-position sweep on a single window, with in_base=14 so reads wrap modulo 16
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 16; i++) b_mem[i] = DATA_BITS'(1);
            b_mem[(14 + (k / 2) * 2 + (k % 2)) % 16] = DATA_BITS'(200);
            run_b(14, 15, $sformatf("sweep_k%0d", k));
        end

        // All-zero window
        for (int i = 0; i < 16; i++) b_mem[i] = '0;
        run_b(6, 3, "zero");

        // Random window and bases
        for (int i = 0; i < 16; i++) b_mem[i] = DATA_BITS'($urandom);
        run_b(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), "rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
